// File: rtl/bm_buf_alloc.sv
// Buffer allocator: circular free list with FWFT head prefetch, plus packet chain link writer.
// Define BM_ALLOC_ERR_CHK_EN to drop over-full/INIT frees and drive the sticky alloc_err flag.
`ifndef BUF_PTR_NBITS
`define BUF_PTR_NBITS 4
`endif

module bm_buf_alloc #(
  parameter int unsigned BUF_PTR_NBITS = `BUF_PTR_NBITS,
  parameter int unsigned NUM_BUFS      = 1 << BUF_PTR_NBITS
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     alloc_req,
  input  logic                     alloc_sop,
  input  logic                     alloc_eop,
  output logic                     alloc_rdy,
  output logic [BUF_PTR_NBITS-1:0] alloc_buf_ptr,
  input  logic                     free_valid,
  input  logic [BUF_PTR_NBITS-1:0] free_buf_ptr,
  output logic                     enq_buf_valid,
  output logic [BUF_PTR_NBITS-1:0] enq_buf_ptr_cur,
  output logic [BUF_PTR_NBITS-1:0] enq_buf_ptr_nxt,
  output logic                     init_done,
  output logic [BUF_PTR_NBITS:0]   free_count,
  output logic                     alloc_err
);

  localparam logic [BUF_PTR_NBITS:0]   NumBufsC = (BUF_PTR_NBITS + 1)'(NUM_BUFS);
  localparam logic [BUF_PTR_NBITS-1:0] LastIdxC = BUF_PTR_NBITS'(NUM_BUFS - 1);
  localparam logic [BUF_PTR_NBITS-1:0] PtrOneC  = BUF_PTR_NBITS'(1);
  localparam logic [BUF_PTR_NBITS:0]   CntOneC  = (BUF_PTR_NBITS + 1)'(1);

  typedef enum logic [1:0] {StInit, StIdle, StPkt} state_e;

  function automatic logic [BUF_PTR_NBITS-1:0] ptr_inc(input logic [BUF_PTR_NBITS-1:0] p);
    return (p == LastIdxC) ? '0 : p + PtrOneC;
  endfunction

  state_e                   r_state;
  logic [BUF_PTR_NBITS-1:0] r_mem [NUM_BUFS];
  logic [BUF_PTR_NBITS-1:0] r_init_cnt;
  logic [BUF_PTR_NBITS-1:0] r_head;
  logic [BUF_PTR_NBITS-1:0] r_tail;
  logic [BUF_PTR_NBITS-1:0] r_rd_ptr;
  logic [BUF_PTR_NBITS-1:0] r_head_ptr;
  logic [BUF_PTR_NBITS-1:0] r_last_ptr;
  logic [BUF_PTR_NBITS-1:0] r_enq_cur;
  logic [BUF_PTR_NBITS-1:0] r_enq_nxt;
  logic                     r_enq_valid;
  logic                     r_init_done;
  logic                     r_rd_valid;
  logic                     r_head_valid;
  logic [BUF_PTR_NBITS:0]   r_free_count;

  logic                     w_xfer;
  logic                     w_free_push;
  logic                     w_issue;
  logic                     w_head_adv;
  logic [1:0]               w_occ;
  logic [1:0]               w_occ_after;
  logic [BUF_PTR_NBITS:0]   w_ram_cnt;
  logic                     w_mem_we;
  logic [BUF_PTR_NBITS-1:0] w_mem_waddr;
  logic [BUF_PTR_NBITS-1:0] w_mem_wdata;

  assign alloc_rdy = r_init_done & (r_free_count != '0) & r_head_valid;
  assign w_xfer    = alloc_req & alloc_rdy;

  // Entries still in the RAM = pool count minus those already in the read stage / head register.
  assign w_occ       = {1'b0, r_head_valid} + {1'b0, r_rd_valid};
  assign w_occ_after = w_occ - {1'b0, w_xfer};
  assign w_ram_cnt   = r_free_count - (BUF_PTR_NBITS + 1)'(w_occ);
  assign w_issue     = r_init_done & (w_ram_cnt != '0) & (w_occ_after != 2'd2);
  assign w_head_adv  = ~r_head_valid | w_xfer;

`ifdef BM_ALLOC_ERR_CHK_EN
  logic w_free_full;
  logic w_proto_err;
  logic r_alloc_err;

  assign w_free_full = (r_free_count == NumBufsC);
  assign w_free_push = free_valid & r_init_done & ~w_free_full;
  assign w_proto_err = w_xfer & (((r_state == StIdle) & ~alloc_sop) |
                                 ((r_state == StPkt) & alloc_sop));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_alloc_err <= 1'b0;
    end else if (w_proto_err | (free_valid & ~w_free_push)) begin
      r_alloc_err <= 1'b1;
    end
  end

  assign alloc_err = r_alloc_err;
`else
  assign w_free_push = free_valid;
  assign alloc_err   = 1'b0;
`endif

  // INIT owns the write port; afterwards it carries returned buffers.
  assign w_mem_we    = (r_state == StInit) | w_free_push;
  assign w_mem_waddr = (r_state == StInit) ? r_init_cnt : r_tail;
  assign w_mem_wdata = (r_state == StInit) ? r_init_cnt : free_buf_ptr;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Pool bookkeeping and the two-stage prefetch (RAM read stage, then head register).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_rd_ptr     <= '0;
      r_rd_valid   <= 1'b0;
      r_head_ptr   <= '0;
      r_head_valid <= 1'b0;
      r_free_count <= '0;
      r_init_done  <= 1'b0;
    end else begin
      if (!r_init_done) begin
        if (r_state != StInit) begin
          r_init_done  <= 1'b1;
          r_free_count <= NumBufsC;
        end
      end else begin
        case ({w_xfer, w_free_push})
          2'b10:   r_free_count <= r_free_count - CntOneC;
          2'b01:   r_free_count <= r_free_count + CntOneC;
          default: r_free_count <= r_free_count;
        endcase
      end

      if (w_free_push) begin
        r_tail <= ptr_inc(r_tail);
      end

      if (w_issue) begin
        r_rd_ptr   <= r_mem[r_head];
        r_rd_valid <= 1'b1;
        r_head     <= ptr_inc(r_head);
      end else if (w_head_adv) begin
        r_rd_valid <= 1'b0;
      end

      if (w_head_adv) begin
        r_head_valid <= r_rd_valid;
        if (r_rd_valid) begin
          r_head_ptr <= r_rd_ptr;
        end
      end
    end
  end

  // Chain FSM; a sop in PKT abandons the open chain, a non-sop in IDLE starts one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= StInit;
      r_init_cnt  <= '0;
      r_last_ptr  <= '0;
      r_enq_valid <= 1'b0;
      r_enq_cur   <= '0;
      r_enq_nxt   <= '0;
    end else begin
      r_enq_valid <= 1'b0;
      case (r_state)
        StInit: begin
          if (r_init_cnt == LastIdxC) begin
            r_init_cnt <= '0;
            r_state    <= StIdle;
          end else begin
            r_init_cnt <= r_init_cnt + PtrOneC;
          end
        end
        StIdle: begin
          if (w_xfer) begin
            r_last_ptr <= r_head_ptr;
            if (!alloc_eop) begin
              r_state <= StPkt;
            end
          end
        end
        StPkt: begin
          if (w_xfer) begin
            r_last_ptr <= r_head_ptr;
            if (!alloc_sop) begin
              r_enq_valid <= 1'b1;
              r_enq_cur   <= r_last_ptr;
              r_enq_nxt   <= r_head_ptr;
            end
            if (alloc_eop) begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign alloc_buf_ptr   = r_head_ptr;
  assign enq_buf_valid   = r_enq_valid;
  assign enq_buf_ptr_cur = r_enq_cur;
  assign enq_buf_ptr_nxt = r_enq_nxt;
  assign init_done       = r_init_done;
  assign free_count      = r_free_count;

endmodule

// File: doc/bm_buf_alloc.md
# bm_buf_alloc

Buffer allocator and chain builder for the buffer manager. It owns the free-buffer pool and hands out one buffer pointer per buffer-sized chunk to the packet writer. It produces the link writes (`enq_buf_valid`, `enq_buf_ptr_cur`, `enq_buf_ptr_nxt`) consumed by the linked-list block, so each packet's buffers form a chain. Freed buffers return to the pool through a separate port.

## Interface
Parameters:
- `BUF_PTR_NBITS`, default `` `BUF_PTR_NBITS ``: buffer pointer width.
- `NUM_BUFS`, default `1<<BUF_PTR_NBITS`: pool size. Legal range is 2..`1<<BUF_PTR_NBITS`.

Ports:
- `clk`  in  1  clock.
- `` `RESET_SIG `` (`rstn`)  in  1  reset. One clock; reset is synchronous and active-low.
- `alloc_req`  in  1  writer requests a buffer.
- `alloc_sop`  in  1  requested buffer is the first of a packet. Qualified by `alloc_req`.
- `alloc_eop`  in  1  requested buffer is the last of a packet. Qualified by `alloc_req`.
- `alloc_rdy`  out  BUF_PTR  1  pool can grant a buffer this cycle.
- `alloc_buf_ptr`  out  `BUF_PTR_NBITS`  granted pointer. Valid when `alloc_rdy`.
- `free_valid`  in  1  buffer return.
- `free_buf_ptr`  in  `BUF_PTR_NBITS`  returned pointer.
- `enq_buf_valid`  out  1  link write strobe.
- `enq_buf_ptr_cur`  out  `BUF_PTR_NBITS`  link source: the previous buffer.
- `enq_buf_ptr_nxt`  out  `BUF_PTR_NBITS`  link target: the new buffer.
- `init_done`  out  1  pool initialised.
- `free_count`  out  `BUF_PTR_NBITS+1`  buffers currently in the pool.
- `alloc_err`  out  1  sticky protocol/pool error.

## Operation
- The pool is a circular free list in `ram_1r1w` (depth `NUM_BUFS`).
- Head pointer, tail pointer and count are registers.
- A prefetched head register gives first-word-fall-through on `alloc_buf_ptr`.
- States:
  - INIT: write pointers 0..`NUM_BUFS-1` into the pool, one per cycle, then go to IDLE.
  - IDLE: no packet open.
  - PKT: packet open; `last_ptr` holds the most recent buffer.
- Transfer: `alloc_req & alloc_rdy` in the same cycle.
- `alloc_rdy = init_done & (free_count != 0) & head_valid`.
- On a transfer with sop: `last_ptr <= alloc_buf_ptr`. Go to PKT, or stay in IDLE if eop is also set (single-buffer packet). No link write.
- On a transfer without sop, in PKT: link write `cur=last_ptr`, `nxt=alloc_buf_ptr`, then `last_ptr <= alloc_buf_ptr`. If eop is set, go to IDLE.
- Last buffer of a packet: no terminal link is written. Readers bound the chain by packet length.
- Protocol errors, each setting `alloc_err`:
  - Non-sop transfer in IDLE: treated as sop.
  - sop transfer in PKT: the open chain is abandoned and a new one starts.
- Free handling:
  - `free_valid` pushes `free_buf_ptr` at the tail.
  - Free when `free_count==NUM_BUFS`: dropped, sets `alloc_err`.
  - Free during INIT: dropped, sets `alloc_err`.
- Simultaneous transfer and free: both are performed and `free_count` is unchanged.
- Pointer arithmetic on head and tail wraps modulo `NUM_BUFS`. `free_count` saturates logically at 0 and `NUM_BUFS` by the above rules.

## Timing
- Reset values: `alloc_rdy=0`, `alloc_buf_ptr=0`, `enq_buf_valid=0`, `enq_buf_ptr_cur=0`, `enq_buf_ptr_nxt=0`, `init_done=0`, `free_count=0`, `alloc_err=0`. State is INIT.
- INIT lasts `NUM_BUFS` cycles after reset deasserts.
- `init_done` and `free_count=NUM_BUFS` rise on the next cycle.
- `alloc_rdy` rises 2 cycles after `init_done`, because of the head prefetch.
- Link write: `enq_buf_*` are registered and asserted exactly 1 cycle after the transfer, for 1 cycle.
- Back-to-back transfers are supported at 1 per cycle.
- Free-to-allocatable latency: a pointer freed while the pool is empty appears on `alloc_buf_ptr` with `alloc_rdy=1` 3 cycles after `free_valid`.
- `free_count` updates 1 cycle after the transfer or free.
- Reset mid-packet: state returns to INIT, no link write is emitted, and the pool is rebuilt.

## Configuration
- `BM_ALLOC_ERR_CHK_EN` defined:
  - Error detection as above; `alloc_err` is sticky until reset.
  - Over-full frees and frees during INIT are dropped.
- `BM_ALLOC_ERR_CHK_EN` undefined:
  - `alloc_err` is tied 0.
  - Full and INIT checks are removed: frees are always pushed, and overflow corrupts the pool. This case is not verified.
  - Protocol-error state handling (sop/non-sop recovery) is unchanged.

## Test plan
- Reset with `NUM_BUFS=16` -> `init_done` at cycle 17, `free_count=16`. Allocations in order return pointers 0,1,2,...
- Packet of 3 buffers (sop, -, eop) granted ptrs 0,1,2 -> link writes (0->1) and (1->2) on consecutive cycles. No write for the sop grant. State ends in IDLE.
- Allocate all 16, then `alloc_rdy=0` with `alloc_req` held. Free ptr 7 -> `alloc_rdy=1` with `alloc_buf_ptr=7` exactly 3 cycles later.
- Simultaneous grant and free for 20 cycles at `free_count=8` -> `free_count` stays 8. Freed pointers are re-granted in FIFO order.
- Macro defined: free when `free_count=16` -> dropped, `alloc_err=1` sticky. Non-sop request in IDLE -> no link write, `alloc_err=1`.
- Assert reset in PKT after 2 grants -> no `enq_buf_valid` afterwards, and INIT reruns to `free_count=16`.
